// File: rtl/arith_pkg.sv
// Shared constants and helpers for the bit-serial arithmetic blocks.
// Serial bit-order selectors and a constant-evaluable ceil(log2).
package arith_pkg;

    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Serial shifter: word register, bit counter and busy flag.
// Loads a word, shifts it out one bit per transfer, flags first/last.
module piso_shift
    import arith_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = arith_pkg::LSB_FIRST
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             sout_o,
    output logic             first_o,
    output logic             last_o,
    output logic             last_xfer_o
);

    localparam int            CW       = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam bit            OUT_MSB  = (MSB_FIRST != arith_pkg::LSB_FIRST);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             xfer;
    logic             at_last;
    logic             out_bit;

    assign xfer        = busy_q & ready_i;
    assign at_last     = (cnt_q == CNT_LAST);
    assign last_xfer_o = xfer & at_last;
    assign out_bit     = OUT_MSB ? sr_q[WIDTH-1] : sr_q[0];

    assign busy_o  = busy_q;
    assign sout_o  = busy_q & out_bit;
    assign first_o = busy_q & (cnt_q == '0);
    assign last_o  = busy_q & at_last;

    // Next state: shift on transfer, a load overrides the drained word.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (xfer) begin
            if (at_last) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (OUT_MSB) begin
                    sr_d = {sr_q[WIDTH-2:0], 1'b0};
                end else begin
                    sr_d = {1'b0, sr_q[WIDTH-1:1]};
                end
            end
        end
        if (load_i) begin
            sr_d   = data_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    // Shifter state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/piso_reg.sv
// Parallel-in serial-out transmitter with a one-word holding register.
// The hold stage lets the next word wait so the serial stream is gapless.
module piso_reg
    import arith_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = arith_pkg::LSB_FIRST
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_first,
    output logic             sout_last
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             busy;
    logic             last_xfer;
    logic             load;
    logic             accept;

    // in_ready comes only from the hold flag, never from sout_ready.
    assign in_ready = ~hold_valid_q;
    assign accept   = in_valid & ~hold_valid_q;
    assign load     = hold_valid_q & (~busy | last_xfer);
    assign sout_valid = busy;

    piso_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load),
        .data_i      (hold_q),
        .ready_i     (sout_ready),
        .busy_o      (busy),
        .sout_o      (sout),
        .first_o     (sout_first),
        .last_o      (sout_last),
        .last_xfer_o (last_xfer)
    );

    // Hold register: fill on accept, drain on load (never both at once).
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule
